tone_sequencer: RTL and testbench

//  Multi-event sound-effect tone generator for the game audio path.

---
 rtl/tone_sequencer.sv | 159 +++++++++++++++
 tb/tb_tone_sequencer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tone_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tone_sequencer
//  Purpose  : Multi-event sound-effect tone generator. Each event input
//             selects a divider/duration pair from parameter tables; while a
//             tone plays, a one-cycle tick is produced every DIV+1 cycles and
//             a square wave toggles on each tick for DUR cycles. Supports
//             priority preemption, same-event retrigger and a global enable.
//  Ports    : clk        - system clock
//             nRst       - asynchronous active-low reset
//             en         - audio enable (game active and not muted)
//             evt        - event request pulses, index 0 = highest priority
//             tick       - one-cycle pulse at divider rollover
//             tone       - square wave, toggles on each tick
//             busy       - high while a tone is playing
//             active_evt - index of the playing event (0 when idle)
//  Revision : 1.0 - initial release
// ============================================================================
module tone_sequencer #(
    parameter int                     NUM_EVT   = 4,
    parameter int                     DIV_W     = 8,
    parameter int                     DUR_W     = 24,
    parameter logic [NUM_EVT*DIV_W-1:0] DIV_TABLE = {8'd240, 8'd60, 8'd109, 8'd188},
    parameter logic [NUM_EVT*DUR_W-1:0] DUR_TABLE = {24'd1000000, 24'd2000000,
                                                     24'd4000000, 24'd10000000},
    parameter bit                     RETRIGGER = 1'b1,
    localparam int                    IDX_W     = (NUM_EVT > 1) ? $clog2(NUM_EVT) : 1
) (
    input  logic               clk,
    input  logic               nRst,
    input  logic               en,
    input  logic [NUM_EVT-1:0] evt,
    output logic               tick,
    output logic               tone,
    output logic               busy,
    output logic [IDX_W-1:0]   active_evt
);

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    state_t           state_q;
    logic [IDX_W-1:0] idx_q;
    logic [DIV_W-1:0] div_q;
    logic [DUR_W-1:0] dur_q;
    logic [DIV_W-1:0] div_cnt_q;
    logic [DUR_W-1:0] dur_cnt_q;
    logic             tick_q;
    logic             tone_q;
    logic             busy_q;

    // ------------------------------------------------------------------
    // Winner selection: lowest set index whose duration entry is non-zero.
    // Scanning from the top down lets the lowest index overwrite last.
    // ------------------------------------------------------------------
    logic             win_vld;
    logic [IDX_W-1:0] win_idx;
    logic [DIV_W-1:0] win_div;
    logic [DUR_W-1:0] win_dur;

    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        win_div = '0;
        win_dur = '0;
        for (int i = NUM_EVT - 1; i >= 0; i--) begin
            if (evt[i] && (DUR_TABLE[i*DUR_W +: DUR_W] != '0)) begin
                win_vld = 1'b1;
                win_idx = IDX_W'(i);
                win_div = DIV_TABLE[i*DIV_W +: DIV_W];
                win_dur = DUR_TABLE[i*DUR_W +: DUR_W];
            end
        end
    end

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    logic last_cyc;   // current cycle is the final cycle of the tone
    logic start;      // load a new tone at this edge
    logic retrig;     // same event re-requested while playing
    logic go_idle;    // abort or natural end of the tone
    logic rollover;   // divider reached its terminal count

    // dur_cnt_q counts 0..dur-1 over the tone, so dur-1 marks the last cycle.
    assign last_cyc = (state_q == PLAY) && (dur_cnt_q == (dur_q - DUR_W'(1)));

    // A new tone starts from idle, back-to-back on the final cycle, or when a
    // strictly higher-priority event preempts the current one.
    assign start    = en && win_vld &&
                      ((state_q == IDLE) || last_cyc || (win_idx < idx_q));

    assign retrig   = RETRIGGER && win_vld && (win_idx == idx_q);

    // Exit takes precedence over a coincident divider rollover.
    assign go_idle  = !en || (last_cyc && !start);

    assign rollover = (div_cnt_q == div_q);

    // ------------------------------------------------------------------
    // Sequencer FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            div_q     <= '0;
            dur_q     <= '0;
            div_cnt_q <= '0;
            dur_cnt_q <= '0;
            tick_q    <= 1'b0;
            tone_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else if (go_idle) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            div_cnt_q <= '0;
            dur_cnt_q <= '0;
            tick_q    <= 1'b0;
            tone_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else if (start) begin
            // Fresh tone: timing restarts exactly as from idle.
            state_q   <= PLAY;
            idx_q     <= win_idx;
            div_q     <= win_div;
            dur_q     <= win_dur;
            div_cnt_q <= '0;
            dur_cnt_q <= '0;
            tick_q    <= 1'b0;
            tone_q    <= 1'b0;
            busy_q    <= 1'b1;
        end else if (state_q == PLAY) begin
            if (rollover) begin
                div_cnt_q <= '0;
                tick_q    <= 1'b1;
                tone_q    <= ~tone_q;
            end else begin
                div_cnt_q <= div_cnt_q + DIV_W'(1);
                tick_q    <= 1'b0;
            end
            // Retrigger only restarts the duration; divider phase carries on.
            if (retrig) begin
                dur_cnt_q <= '0;
            end else begin
                dur_cnt_q <= dur_cnt_q + DUR_W'(1);
            end
        end
    end

    assign tick       = tick_q;
    assign tone       = tone_q;
    assign busy       = busy_q;
    assign active_evt = idx_q;

endmodule
`default_nettype wire

// File: tb/tb_tone_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tone_sequencer
//  Purpose  : Self-checking bench for tone_sequencer. A cycle-indexed model
//             describes each tone by its start edge, end edge and divider
//             period and derives tick/tone/busy arithmetically; directed
//             scenarios add literal expectations at hand-computed cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tone_sequencer;

    localparam int NE      = 4;
    localparam bit RETRIG  = 1'b1;

    // Per-event tables as plain integers (index = event number).
    int DIVT [NE] = '{2, 1, 0, 3};
    int DURT [NE] = '{12, 0, 5, 8};

    logic          clk  = 1'b0;
    logic          nRst = 1'b0;
    logic          en   = 1'b0;
    logic [NE-1:0] evt  = '0;
    logic          tick;
    logic          tone;
    logic          busy;
    logic [1:0]    active_evt;

    always #5 clk = ~clk;

    tone_sequencer #(
        .NUM_EVT   (NE),
        .DIV_W     (8),
        .DUR_W     (24),
        .DIV_TABLE ({8'd3, 8'd0, 8'd1, 8'd2}),
        .DUR_TABLE ({24'd8, 24'd5, 24'd0, 24'd12}),
        .RETRIGGER (RETRIG)
    ) dut (
        .clk        (clk),
        .nRst       (nRst),
        .en         (en),
        .evt        (evt),
        .tick       (tick),
        .tone       (tone),
        .busy       (busy),
        .active_evt (active_evt)
    );

    int total = 0;
    int bad   = 0;
    int ec    = 0;   // number of rising edges seen; during cycle c, ec == c

    always @(posedge clk) ec <= ec + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at t=%0t: actual=%0d required=%0d", nm, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: a tone is (start edge k, last cycle m_end, event index).
    // In cycle c+1 of a tone started at edge k, d = c-k cycles have elapsed;
    // ticks fall where d is a positive multiple of DIV+1 and the tone level
    // is the parity of the number of ticks so far.
    // ------------------------------------------------------------------
    bit m_busy = 1'b0;
    int m_idx  = 0;
    int m_k    = 0;
    int m_end  = 0;
    bit e_tick = 1'b0;
    bit e_tone = 1'b0;
    bit e_busy = 1'b0;
    int e_act  = 0;

    task automatic model_step(input int c);
        int w;
        bit fin;
        int d;
        int p;
        w = -1;
        for (int i = NE - 1; i >= 0; i--) begin
            if (evt[i] && DURT[i] != 0) w = i;
        end
        if (!en) begin
            m_busy = 1'b0;
        end else begin
            fin = m_busy && (c == m_end);
            if (w >= 0 && (!m_busy || fin || w < m_idx)) begin
                m_busy = 1'b1;
                m_idx  = w;
                m_k    = c;
                m_end  = c + DURT[w];
            end else if (fin) begin
                m_busy = 1'b0;
            end else if (m_busy && RETRIG && w == m_idx) begin
                m_end = c + DURT[w];
            end
        end
        if (!m_busy) m_idx = 0;
        e_busy = m_busy;
        e_act  = m_idx;
        if (m_busy) begin
            d      = c - m_k;
            p      = DIVT[m_idx] + 1;
            e_tick = (d > 0) && (d % p == 0);
            e_tone = ((d / p) % 2) == 1;
        end else begin
            e_tick = 1'b0;
            e_tone = 1'b0;
        end
    endtask

    always @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            m_busy = 1'b0;
            m_idx  = 0;
            e_tick = 1'b0;
            e_tone = 1'b0;
            e_busy = 1'b0;
            e_act  = 0;
        end else begin
            model_step(ec);
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("cyc_tick", 32'(tick),       32'(e_tick));
        chk("cyc_tone", 32'(tone),       32'(e_tone));
        chk("cyc_busy", 32'(busy),       32'(e_busy));
        chk("cyc_act",  32'(active_evt), 32'(e_act));
    end

    // Advance to the falling edge inside cycle c (cycle c follows edge c-1).
    task automatic goto(input int c);
        int guard;
        guard = 0;
        while (ec < c && guard < 1000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        @(negedge clk);
    endtask

    int k;
    int m;

    initial begin
        // Reset state
        goto(3);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_tick", 32'(tick), 0);
        chk("rst_tone", 32'(tone), 0);
        chk("rst_act",  32'(active_evt), 0);
        nRst = 1'b1;
        en   = 1'b1;

        // 1: event 0, div 2, dur 12
        k = ec + 2;
        goto(k);      evt = 4'b0001;
        goto(k + 1);  evt = 4'b0000;
        chk("s1_busy_k1", 32'(busy), 1);
        chk("s1_act",     32'(active_evt), 0);
        goto(k + 4);  chk("s1_tick_k4", 32'(tick), 1); chk("s1_tone_k4", 32'(tone), 1);
        goto(k + 5);  chk("s1_tick_k5", 32'(tick), 0);
        goto(k + 7);  chk("s1_tick_k7", 32'(tick), 1); chk("s1_tone_k7", 32'(tone), 0);
        goto(k + 10); chk("s1_tick_k10", 32'(tick), 1); chk("s1_tone_k10", 32'(tone), 1);
        goto(k + 12); chk("s1_busy_k12", 32'(busy), 1);
        goto(k + 13); chk("s1_busy_k13", 32'(busy), 0);
        chk("s1_tone_k13", 32'(tone), 0);
        chk("s1_tick_k13", 32'(tick), 0);

        // 2: zero-duration event masked; event 2 wins with div 0
        k = ec + 2;
        goto(k);      evt = 4'b0010;
        goto(k + 1);  evt = 4'b0000;
        chk("s2_masked_busy", 32'(busy), 0);
        goto(k + 2);  chk("s2_masked_tick", 32'(tick), 0);
        m = k + 3;
        goto(m);      evt = 4'b0110;
        goto(m + 1);  evt = 4'b0000;
        chk("s2_busy", 32'(busy), 1);
        chk("s2_act",  32'(active_evt), 2);
        for (int j = 2; j <= 5; j++) begin
            goto(m + j);
            chk("s2_tick_each", 32'(tick), 1);
        end
        chk("s2_busy_last", 32'(busy), 1);
        goto(m + 6);  chk("s2_busy_end", 32'(busy), 0);

        // 3: event 3 preempted by event 0
        k = ec + 2;
        goto(k);      evt = 4'b1000;
        goto(k + 1);  evt = 4'b0000;
        chk("s3_act3", 32'(active_evt), 3);
        m = k + 6;
        goto(m);      evt = 4'b0001;
        chk("s3_tone_before", 32'(tone), 1);
        goto(m + 1);  evt = 4'b0000;
        chk("s3_act0",  32'(active_evt), 0);
        chk("s3_tone0", 32'(tone), 0);
        chk("s3_busy",  32'(busy), 1);
        goto(m + 3);  chk("s3_tick_m3", 32'(tick), 0);
        goto(m + 4);  chk("s3_tick_m4", 32'(tick), 1);
        goto(m + 12); chk("s3_busy_m12", 32'(busy), 1);
        goto(m + 13); chk("s3_busy_m13", 32'(busy), 0);

        // 4: lower priority ignored, then same-event retrigger at dur_cnt 6
        k = ec + 2;
        goto(k);      evt = 4'b0001;
        goto(k + 1);  evt = 4'b0000;
        goto(k + 2);  evt = 4'b1000;
        goto(k + 3);  evt = 4'b0000;
        chk("s4_ignore_act", 32'(active_evt), 0);
        goto(k + 7);  evt = 4'b0001;
        goto(k + 8);  evt = 4'b0000;
        goto(k + 10); chk("s4_tick_k10", 32'(tick), 1); chk("s4_tone_k10", 32'(tone), 1);
        goto(k + 13); chk("s4_busy_k13", 32'(busy), 1);
        chk("s4_tick_k13", 32'(tick), 1);
        chk("s4_tone_k13", 32'(tone), 0);
        goto(k + 16); chk("s4_tone_k16", 32'(tone), 1);
        goto(k + 19); chk("s4_busy_k19", 32'(busy), 1); chk("s4_tick_k19", 32'(tick), 1);
        goto(k + 20); chk("s4_busy_k20", 32'(busy), 0);

        // 5: back-to-back on final cycle, then enable drop
        k = ec + 2;
        goto(k);      evt = 4'b1000;
        goto(k + 1);  evt = 4'b0000;
        goto(k + 8);  evt = 4'b1000;
        chk("s5_busy_last", 32'(busy), 1);
        chk("s5_tone_last", 32'(tone), 1);
        goto(k + 9);  evt = 4'b0000;
        chk("s5_busy_cont", 32'(busy), 1);
        chk("s5_act",       32'(active_evt), 3);
        chk("s5_tone_rst",  32'(tone), 0);
        goto(k + 11); en = 1'b0;
        goto(k + 12);
        chk("s5_en_busy", 32'(busy), 0);
        chk("s5_en_tick", 32'(tick), 0);
        chk("s5_en_tone", 32'(tone), 0);
        chk("s5_en_act",  32'(active_evt), 0);
        goto(k + 13); evt = 4'b0001;
        goto(k + 14); evt = 4'b0000;
        chk("s5_en_evt_ign", 32'(busy), 0);
        en = 1'b1;
        goto(k + 16); chk("s5_no_resume", 32'(busy), 0);

        // 6: async reset mid-tone, then normal operation
        k = ec + 2;
        goto(k);      evt = 4'b0001;
        goto(k + 1);  evt = 4'b0000;
        goto(k + 5);
        chk("s6_pre_busy", 32'(busy), 1);
        #1 nRst = 1'b0;
        #1;
        chk("s6_rst_busy", 32'(busy), 0);
        chk("s6_rst_tone", 32'(tone), 0);
        chk("s6_rst_tick", 32'(tick), 0);
        chk("s6_rst_act",  32'(active_evt), 0);
        goto(k + 7);
        #1 nRst = 1'b1;
        m = k + 9;
        goto(m);      evt = 4'b0001;
        goto(m + 1);  evt = 4'b0000;
        chk("s6_busy_m1", 32'(busy), 1);
        goto(m + 4);  chk("s6_tick_m4", 32'(tick), 1);
        goto(m + 12); chk("s6_busy_m12", 32'(busy), 1);
        goto(m + 13); chk("s6_busy_m13", 32'(busy), 0);

        goto(ec + 2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Bound on total run time.
    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog: actual=timeout required=finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
